// File: rtl/ingress_port_ctrl.sv
// Per-port ingress FIFO, header decoder and all-or-nothing crossbar requester.
// Define INGRESS_DROP_STATS_EN to build the saturating dropped-packet counter.
module ingress_port_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              port_req,
  output logic [3:0]        port_dst,
  input  logic              grant,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [15:0]       drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // ST_HDR is the decode cycle between popping the header and requesting.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_REQ  = 3'd2,
    ST_SEND = 3'd3,
    ST_DROP = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
  logic              wr_en_s, rd_en_s, empty_s, hold_req_s;
  logic [DATA_W-1:0] head_s, hdr_q_r;
  logic [3:0]        rem_r;
  logic              in_ready_r, port_req_r, out_valid_r, out_sop_r, out_eop_r;
  logic [3:0]        port_dst_r;
  logic [DATA_W-1:0] out_data_r;

  function automatic logic ptr_full(input logic [AW:0] wp, input logic [AW:0] rp);
    return (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  endfunction

  assign wr_en_s    = in_valid && in_ready_r;
  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  assign head_s     = mem_r[rd_ptr_r[AW-1:0]];
  assign wr_ptr_s   = wr_en_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
  assign rd_ptr_s   = rd_en_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
  assign hold_req_s = (state_s == ST_REQ) || (state_s == ST_SEND);

  // Next-state and FIFO pop decode
  always_comb begin
    state_s = state_r;
    rd_en_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          rd_en_s = 1'b1;
          state_s = ST_HDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (hdr_q_r[3:0] == 4'b0000) begin
          state_s = ST_DROP;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_REQ: begin
        if (grant) begin
          state_s = ST_SEND;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_SEND: begin
        if (out_eop_r) begin
          state_s = ST_IDLE;
        end else if ((rem_r != 4'd0) && !empty_s) begin
          rd_en_s = 1'b1;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_DROP: begin
        if (rem_r == 4'd0) begin
          state_s = ST_IDLE;
        end else if (!empty_s) begin
          rd_en_s = 1'b1;
          state_s = (rem_r == 4'd1) ? ST_IDLE : ST_DROP;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and FIFO pointers; in_ready tracks the post-edge full flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      wr_ptr_r   <= wr_ptr_s;
      rd_ptr_r   <= rd_ptr_s;
      in_ready_r <= !ptr_full(wr_ptr_s, rd_ptr_s);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= in_data;
    end
  end

  // Header latch and remaining payload count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_q_r <= '0;
      rem_r   <= 4'd0;
    end else if ((state_r == ST_IDLE) && rd_en_s) begin
      hdr_q_r <= head_s;
      rem_r   <= head_s[7:4];
    end else if (rd_en_s) begin
      rem_r   <= rem_r - 4'd1;
    end else begin
      rem_r   <= rem_r;
    end
  end

  // Registered arbiter request and crossbar flit outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_req_r  <= 1'b0;
      port_dst_r  <= 4'b0000;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sop_r   <= 1'b0;
      out_eop_r   <= 1'b0;
    end else begin
      port_req_r  <= hold_req_s;
      port_dst_r  <= hold_req_s ? hdr_q_r[3:0] : 4'b0000;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sop_r   <= 1'b0;
      out_eop_r   <= 1'b0;
      if ((state_r == ST_REQ) && grant) begin
        out_valid_r <= 1'b1;
        out_data_r  <= hdr_q_r;
        out_sop_r   <= 1'b1;
        out_eop_r   <= (hdr_q_r[7:4] == 4'd0);
      end else if ((state_r == ST_SEND) && rd_en_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= head_s;
        out_eop_r   <= (rem_r == 4'd1);
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

`ifdef INGRESS_DROP_STATS_EN
  logic [15:0] drop_cnt_r;

  // Saturating count of packets entering DROP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= 16'h0000;
    end else if ((state_r == ST_HDR) && (state_s == ST_DROP) && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'h0001;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_count = drop_cnt_r;
`else
  assign drop_count = 16'h0000;
`endif

  assign in_ready  = in_ready_r;
  assign port_req  = port_req_r;
  assign port_dst  = port_dst_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sop   = out_sop_r;
  assign out_eop   = out_eop_r;

endmodule

// File: tb/tb_ingress_port_ctrl.sv
// Directed self-checking bench for ingress_port_ctrl; cycle c is the cycle after the edge
// that writes the packet header.
module tb_ingress_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        grant = 1'b0;
  logic        in_ready, port_req, out_valid, out_sop, out_eop;
  logic [3:0]  port_dst;
  logic [7:0]  out_data;
  logic [15:0] drop_count;
  int          nerr = 0;
  int          nchk = 0;

`ifdef INGRESS_DROP_STATS_EN
  localparam logic [15:0] EXP_DROP = 16'd1;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  always #5 clk = ~clk;

  ingress_port_ctrl #(.DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .port_req(port_req), .port_dst(port_dst), .grant(grant), .out_valid(out_valid),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .drop_count(drop_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_flit(input string tag, input logic [7:0] d, input logic sop, input logic eop);
    chk_b({tag, "_valid"}, out_valid, 1'b1);
    chk_w({tag, "_data"}, 16'(out_data), 16'(d));
    chk_b({tag, "_sop"}, out_sop, sop);
    chk_b({tag, "_eop"}, out_eop, eop);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_b({tag, "_in_ready"}, in_ready, 1'b0);
    chk_b({tag, "_req"}, port_req, 1'b0);
    chk_w({tag, "_dst"}, 16'(port_dst), 16'h0);
    chk_b({tag, "_valid"}, out_valid, 1'b0);
    chk_w({tag, "_data"}, 16'(out_data), 16'h0);
    chk_b({tag, "_sop"}, out_sop, 1'b0);
    chk_b({tag, "_eop"}, out_eop, 1'b0);
  endtask

  initial begin
    // Power-on reset
    #12;
    chk_all_zero("rst");
    chk_w("rst_drop", drop_count, 16'h0);
    rst_n = 1'b1;
    step();
    chk_b("rel_in_ready", in_ready, 1'b1);

    // Unicast 8'h32, grant tied high
    grant = 1'b1;
    in_valid = 1'b1; in_data = 8'h32; step();
    in_data = 8'hA1; step();
    chk_b("t1_c1_req", port_req, 1'b0);
    in_data = 8'hA2; step();
    chk_b("t1_c2_req", port_req, 1'b1);
    chk_w("t1_c2_dst", 16'(port_dst), 16'h2);
    chk_b("t1_c2_valid", out_valid, 1'b0);
    in_data = 8'hA3; step();
    in_valid = 1'b0;
    expect_flit("t1_c3", 8'h32, 1'b1, 1'b0);
    step(); expect_flit("t1_c4", 8'hA1, 1'b0, 1'b0);
    step(); expect_flit("t1_c5", 8'hA2, 1'b0, 1'b0);
    step(); expect_flit("t1_c6", 8'hA3, 1'b0, 1'b1);
    chk_b("t1_c6_req", port_req, 1'b1);
    step();
    chk_b("t1_c7_req", port_req, 1'b0);
    chk_w("t1_c7_dst", 16'(port_dst), 16'h0);
    chk_b("t1_c7_valid", out_valid, 1'b0);
    step(); step();

    // Same packet, grant withheld for 10 cycles
    grant = 1'b0;
    in_valid = 1'b1; in_data = 8'h32; step();
    in_data = 8'hA1; step();
    in_data = 8'hA2; step();
    in_data = 8'hA3;
    for (int c = 2; c <= 11; c++) begin
      chk_b("t2_req", port_req, 1'b1);
      chk_w("t2_dst", 16'(port_dst), 16'h2);
      chk_b("t2_valid", out_valid, 1'b0);
      if (c == 3) in_valid = 1'b0;
      if (c == 11) grant = 1'b1;
      step();
    end
    expect_flit("t2_c12", 8'h32, 1'b1, 1'b0);
    step(); expect_flit("t2_c13", 8'hA1, 1'b0, 1'b0);
    step(); expect_flit("t2_c14", 8'hA2, 1'b0, 1'b0);
    step(); expect_flit("t2_c15", 8'hA3, 1'b0, 1'b1);
    step();
    chk_b("t2_c16_req", port_req, 1'b0);
    step(); step();

    // Mask 0 with LEN 5: dropped silently
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 6);
      in_data  = (i == 0) ? 8'h50 : 8'(8'hC0 + i);
      step();
      chk_b("t3_req", port_req, 1'b0);
      chk_b("t3_valid", out_valid, 1'b0);
    end
    chk_w("t3_drop_count", drop_count, EXP_DROP);
    chk_b("t3_in_ready", in_ready, 1'b1);

    // Multicast 8'h0F, LEN 0
    in_valid = 1'b1; in_data = 8'h0F; step();
    in_valid = 1'b0; step();
    step();
    chk_b("t4_c2_req", port_req, 1'b1);
    chk_w("t4_c2_dst", 16'(port_dst), 16'hF);
    step();
    expect_flit("t4_c3", 8'h0F, 1'b1, 1'b1);
    chk_w("t4_c3_dst", 16'(port_dst), 16'hF);
    step();
    chk_b("t4_c4_req", port_req, 1'b0);
    chk_b("t4_c4_valid", out_valid, 1'b0);
    step(); step();

    // Fill the FIFO while blocked in REQ: 15 payloads plus the next header
    grant = 1'b0;
    in_valid = 1'b1; in_data = 8'hF1; step();
    for (int k = 1; k <= 15; k++) begin
      in_data = 8'(8'h10 + k);
      step();
      chk_b("t5_fill_in_ready", in_ready, 1'b1);
    end
    in_data = 8'h04; step();
    chk_b("t5_c16_in_ready", in_ready, 1'b0);
    chk_b("t5_c16_req", port_req, 1'b1);
    chk_w("t5_c16_dst", 16'(port_dst), 16'h1);
    chk_b("t5_c16_valid", out_valid, 1'b0);
    in_data = 8'hEE; grant = 1'b1; step();
    in_valid = 1'b0;
    expect_flit("t5_c17", 8'hF1, 1'b1, 1'b0);
    chk_b("t5_c17_in_ready", in_ready, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      step();
      expect_flit("t5_pay", 8'(8'h10 + k), 1'b0, (k == 15));
      if (k == 1) chk_b("t5_c18_in_ready", in_ready, 1'b1);
    end
    step(); chk_b("t5_c33_valid", out_valid, 1'b0);
    step(); step();
    chk_b("t5_c35_req", port_req, 1'b1);
    chk_w("t5_c35_dst", 16'(port_dst), 16'h4);
    chk_b("t5_c35_valid", out_valid, 1'b0);
    step(); expect_flit("t5_c36", 8'h04, 1'b1, 1'b1);
    step(); chk_b("t5_c37_req", port_req, 1'b0);
    step(); step();
    chk_b("t5_c39_req", port_req, 1'b0);
    chk_b("t5_c39_valid", out_valid, 1'b0);
    step();

    // Slow payload writes produce bubbles
    in_valid = 1'b1; in_data = 8'h38; step();
    for (int c = 0; c <= 13; c++) begin
      logic ev;
      ev = (c == 3) || (c == 6) || (c == 9) || (c == 12);
      chk_b("t6_valid", out_valid, ev);
      if (ev) chk_w("t6_data", 16'(out_data),
                    (c == 3) ? 16'h38 : (c == 6) ? 16'hD1 : (c == 9) ? 16'hD2 : 16'hD3);
      chk_b("t6_req", port_req, (c >= 2) && (c <= 12));
      chk_b("t6_eop", out_eop, (c == 12));
      in_valid = (c == 4) || (c == 7) || (c == 10);
      in_data  = (c == 4) ? 8'hD1 : (c == 7) ? 8'hD2 : 8'hD3;
      step();
    end
    in_valid = 1'b0;
    step();

    // Asynchronous reset in the middle of SEND
    in_valid = 1'b1; in_data = 8'h32; step();
    in_data = 8'hA1; step();
    in_data = 8'hA2; step();
    in_data = 8'hA3; step();
    in_valid = 1'b0;
    step();
    expect_flit("t7_c4", 8'hA1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("t7_async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_b("t7_post_req", port_req, 1'b0);
      chk_b("t7_post_valid", out_valid, 1'b0);
      chk_b("t7_post_in_ready", in_ready, 1'b1);
    end
    in_valid = 1'b1; in_data = 8'h0F; step();
    in_valid = 1'b0; step();
    step(); step();
    expect_flit("t7_after", 8'h0F, 1'b1, 1'b1);
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
